// File: rtl/pac_pll_pkg.sv
// Shared PAC-PLL constants and the volume-ramp state encoding.
// The output volume mixer uses the same constants.
package pac_pll_pkg;

    localparam int SV_AXIS_W   = 16;
    localparam int VOL_Q_FRAC  = 14;
    localparam int VOL_ONE_Q14 = 1 << VOL_Q_FRAC;

    typedef enum logic [1:0] {
        VOL_IDLE      = 2'd0,
        VOL_RAMP      = 2'd1,
        VOL_HOLD      = 2'd2,
        VOL_RAMP_DOWN = 2'd3
    } vol_state_t;

endpackage

// File: rtl/ramp_tick_prescaler.sv
// Rate prescaler for the volume ramp: one tick every decim+1 cycles.
// A new decim value takes effect only at the next reload.
module ramp_tick_prescaler #(
    parameter int DECIM_WIDTH = 16
) (
    input  logic                   a_clk,
    input  logic                   a_resetn,
    input  logic [DECIM_WIDTH-1:0] decim,
    output logic                   tick
);

    logic [DECIM_WIDTH-1:0] cnt_reg;

    assign tick = (cnt_reg == '0);

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= decim;
        end else begin
            cnt_reg <= cnt_reg - DECIM_WIDTH'(1);
        end
    end

endmodule

// File: rtl/volume_ramp_source.sv
// SV_AXIS volume source: slews a Q14 gain word toward a clamped target at a
// programmed rate, or toward zero when disabled, without ever overshooting.
module volume_ramp_source
    import pac_pll_pkg::*;
#(
    parameter int VAXIS_DATA_WIDTH = SV_AXIS_W,
    parameter int FRAC_BITS        = 16,
    parameter int VOL_MAX          = VOL_ONE_Q14,
    parameter int DECIM_WIDTH      = 16
) (
    input  logic                        a_clk,
    input  logic                        a_resetn,
    input  logic                        enable,
    input  logic [VAXIS_DATA_WIDTH-1:0] target,
    input  logic [31:0]                 step,
    input  logic [DECIM_WIDTH-1:0]      decim,
    output logic [VAXIS_DATA_WIDTH-1:0] SV_AXIS_tdata,
    output logic                        SV_AXIS_tvalid,
    output logic                        at_target,
    output logic                        ramping
);

    localparam int ACC_W = VAXIS_DATA_WIDTH + FRAC_BITS;
    localparam logic signed [VAXIS_DATA_WIDTH-1:0] VOL_HI = VAXIS_DATA_WIDTH'(VOL_MAX);
    localparam logic signed [VAXIS_DATA_WIDTH-1:0] VOL_LO = VAXIS_DATA_WIDTH'(-VOL_MAX);

    logic                        enable_reg;
    logic signed [ACC_W-1:0]     tgt_acc_reg;
    logic [31:0]                 step_reg;
    logic [DECIM_WIDTH-1:0]      decim_reg;

    logic signed [VAXIS_DATA_WIDTH-1:0] target_clamped;
    logic signed [ACC_W-1:0]     tgt_acc_next;
    logic signed [ACC_W-1:0]     acc_reg;
    logic signed [ACC_W-1:0]     acc_next;
    logic signed [ACC_W-1:0]     goal;
    logic signed [ACC_W-1:0]     acc_step;
    logic signed [ACC_W:0]       diff;
    logic [ACC_W:0]              diff_mag;
    logic                        land;
    logic                        tick;

    vol_state_t                  state_reg;
    logic [VAXIS_DATA_WIDTH-1:0] tdata_reg;
    logic                        tvalid_reg;
    logic                        at_target_reg;
    logic                        ramping_reg;

    ramp_tick_prescaler #(
        .DECIM_WIDTH (DECIM_WIDTH)
    ) u_prescaler (
        .a_clk    (a_clk),
        .a_resetn (a_resetn),
        .decim    (decim_reg),
        .tick     (tick)
    );

    always_comb begin
        target_clamped = $signed(target);
        if ($signed(target) > VOL_HI) begin
            target_clamped = VOL_HI;
        end else if ($signed(target) < VOL_LO) begin
            target_clamped = VOL_LO;
        end
        tgt_acc_next = {target_clamped, {FRAC_BITS{1'b0}}};
    end

    // One extra bit on diff keeps goal - acc exact for any pair of values.
    always_comb begin
        goal     = enable_reg ? tgt_acc_reg : '0;
        diff     = {goal[ACC_W-1], goal} - {acc_reg[ACC_W-1], acc_reg};
        diff_mag = diff[ACC_W] ? $unsigned(-diff) : $unsigned(diff);
        land     = (step_reg == '0) || ({1'b0, diff_mag} <= (ACC_W+2)'(step_reg));
        acc_step = diff[ACC_W] ? acc_reg - ACC_W'(step_reg) : acc_reg + ACC_W'(step_reg);
        acc_next = acc_reg;
        if (tick) begin
            acc_next = land ? goal : acc_step;
        end
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            enable_reg    <= 1'b0;
            tgt_acc_reg   <= '0;
            step_reg      <= '0;
            decim_reg     <= '0;
            acc_reg       <= '0;
            state_reg     <= VOL_IDLE;
            tdata_reg     <= '0;
            tvalid_reg    <= 1'b0;
            at_target_reg <= 1'b0;
            ramping_reg   <= 1'b0;
        end else begin
            enable_reg  <= enable;
            tgt_acc_reg <= tgt_acc_next;
            step_reg    <= step;
            decim_reg   <= decim;
            acc_reg     <= acc_next;

            // Enable decides the direction; a landing only settles the state.
            if (enable_reg) begin
                state_reg <= (acc_next == tgt_acc_reg) ? VOL_HOLD : VOL_RAMP;
            end else begin
                state_reg <= (acc_next == '0) ? VOL_IDLE : VOL_RAMP_DOWN;
            end

            tdata_reg     <= acc_reg[ACC_W-1:FRAC_BITS];
            tvalid_reg    <= 1'b1;
            at_target_reg <= (state_reg == VOL_HOLD);
            ramping_reg   <= (state_reg == VOL_RAMP) || (state_reg == VOL_RAMP_DOWN);
        end
    end

    assign SV_AXIS_tdata  = tdata_reg;
    assign SV_AXIS_tvalid = tvalid_reg;
    assign at_target      = at_target_reg;
    assign ramping        = ramping_reg;

endmodule

// File: tb/tb_volume_ramp_source.sv
// Bench for volume_ramp_source: clamp vector table, directed ramp sequences
// and randomized segments, all checked against a cycle-level reference model.
module tb_volume_ramp_source;

    logic        a_clk    = 1'b0;
    logic        a_resetn = 1'b0;
    logic        enable   = 1'b0;
    logic [15:0] target   = '0;
    logic [31:0] step     = '0;
    logic [15:0] decim    = '0;
    logic [15:0] SV_AXIS_tdata;
    logic        SV_AXIS_tvalid;
    logic        at_target;
    logic        ramping;

    volume_ramp_source dut (
        .a_clk          (a_clk),
        .a_resetn       (a_resetn),
        .enable         (enable),
        .target         (target),
        .step           (step),
        .decim          (decim),
        .SV_AXIS_tdata  (SV_AXIS_tdata),
        .SV_AXIS_tvalid (SV_AXIS_tvalid),
        .at_target      (at_target),
        .ramping        (ramping)
    );

    always #5 a_clk = ~a_clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_on = 1'b0;

    // Reference model: registered inputs, rate counter, accumulator in
    // plain integers (units of 1/65536 output LSB), and delayed outputs.
    bit     m_en;
    longint m_tgt, m_step, m_acc, m_td;
    int     m_decim, m_cnt, m_state;   // 0 idle, 1 ramp, 2 hold, 3 ramp down
    bit     m_valid, m_at, m_ramp;

    typedef struct {
        logic [15:0] tgt;
        longint      exp_td;
        bit          exp_at;
    } vec_t;
    vec_t vecs[10];

    function automatic longint clamp_q14(longint v);
        if (v > 16384)  return 16384;
        if (v < -16384) return -16384;
        return v;
    endfunction

    function automatic longint sdata();
        return longint'($signed(SV_AXIS_tdata));
    endfunction

    task automatic model_reset();
        m_en = 0; m_tgt = 0; m_step = 0; m_acc = 0; m_td = 0;
        m_decim = 0; m_cnt = 0; m_state = 0;
        m_valid = 0; m_at = 0; m_ramp = 0;
    endtask

    task automatic model_edge();
        longint g, d, mag;
        bit     tk;
        m_td    = m_acc >>> 16;
        m_valid = 1;
        m_at    = (m_state == 2);
        m_ramp  = (m_state == 1) || (m_state == 3);
        tk      = (m_cnt == 0);
        m_cnt   = tk ? m_decim : m_cnt - 1;
        if (tk) begin
            g   = m_en ? m_tgt : 0;
            d   = g - m_acc;
            mag = (d < 0) ? -d : d;
            if (m_step == 0 || mag <= m_step) m_acc = g;
            else m_acc = m_acc + ((d > 0) ? m_step : -m_step);
        end
        if (m_en) m_state = (m_acc == m_tgt) ? 2 : 1;
        else      m_state = (m_acc == 0) ? 0 : 3;
        m_en    = enable;
        m_tgt   = clamp_q14(longint'($signed(target))) * 65536;
        m_step  = longint'(step);
        m_decim = int'(decim);
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("tdata",     sdata(),                 m_td);
        check("tvalid",    longint'(SV_AXIS_tvalid), longint'(m_valid));
        check("at_target", longint'(at_target),      longint'(m_at));
        check("ramping",   longint'(ramping),        longint'(m_ramp));
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge a_clk);
            if (!a_resetn) model_reset();
            else model_edge();
            @(negedge a_clk);
            if (model_on) compare_model();
        end
    endtask

    task automatic run_until(input string name, input longint val, input int budget, output int edges);
        edges = 0;
        while (sdata() != val && edges < budget) begin
            cycle(1);
            edges++;
        end
        check(name, sdata(), val);
    endtask

    initial begin
        int  e;
        longint v;
        vecs[0] = '{16'h7FFF, 16384, 1'b1};
        vecs[1] = '{16'h8000, -16384, 1'b1};
        vecs[2] = '{16'h4000, 16384, 1'b1};
        vecs[3] = '{16'h4001, 16384, 1'b1};
        vecs[4] = '{16'hBFFF, -16384, 1'b1};
        vecs[5] = '{16'hC000, -16384, 1'b1};
        vecs[6] = '{16'd12345, 12345, 1'b1};
        vecs[7] = '{16'hFFFF, -1, 1'b1};
        vecs[8] = '{16'd1, 1, 1'b1};
        vecs[9] = '{16'd0, 0, 1'b1};

        // Reset state and release
        model_reset();
        cycle(3);
        check("rst_tdata",  sdata(), 0);
        check("rst_tvalid", longint'(SV_AXIS_tvalid), 0);
        check("rst_at",     longint'(at_target), 0);
        check("rst_ramp",   longint'(ramping), 0);
        a_resetn = 1'b1;
        cycle(1);
        check("tvalid_rise", longint'(SV_AXIS_tvalid), 1);
        check("idle_at",     longint'(at_target), 0);
        check("idle_ramp",   longint'(ramping), 0);
        model_on = 1'b1;
        $display("[TB] reset: tdata=%0d tvalid=%0b", sdata(), SV_AXIS_tvalid);

        // Clamp table: immediate jumps, visible three cycles later
        enable = 1'b1; step = 0; decim = 0;
        for (int i = 0; i < 10; i++) begin
            target = vecs[i].tgt;
            cycle(3);
            check("clamp_td", sdata(), vecs[i].exp_td);
            check("clamp_at", longint'(at_target), longint'(vecs[i].exp_at));
            $display("[TB] clamp target=%0d -> tdata=%0d at_target=%0b",
                     $signed(vecs[i].tgt), sdata(), at_target);
        end

        // Full-scale ramp, one LSB per cycle
        target = 16'd16384; step = 32'h1_0000;
        run_until("ramp_full", 16384, 20000, e);
        check("ramp_edges", e, 16386);
        check("ramp_at",    longint'(at_target), 1);
        check("ramp_idle",  longint'(ramping), 0);
        $display("[TB] ramp 0->16384 in %0d cycles", e);

        // Step 0 jump latency
        target = 16'd8192; step = 0;
        cycle(2);
        check("lat2", sdata(), 16384);
        cycle(1);
        check("lat3", sdata(), 8192);
        $display("[TB] jump 16384->8192 tdata=%0d", sdata());

        // Mid-ramp direction reversal
        target = 16'd0;
        cycle(4);
        target = 16'd16384; step = 32'h1_0000;
        run_until("mid_4000", 4000, 5000, e);
        target = 16'hF000;
        cycle(3);
        check("reverse", sdata(), 4001);
        run_until("land_neg", -4096, 9000, e);
        cycle(20);
        check("land_hold", sdata(), -4096);
        check("land_at",   longint'(at_target), 1);
        $display("[TB] reversal landed at %0d", sdata());

        // Prescaled ramp into the clamp
        step = 0; target = 16'd16000;
        cycle(4);
        decim = 16'd9; step = 32'h2_0000; target = 16'h7FFF;
        cycle(20);
        v = sdata();
        cycle(10);
        check("decim_delta", sdata() - v, 2);
        run_until("clamp_ramp", 16384, 3000, e);
        decim = 0;
        cycle(30);
        check("clamp_hold", sdata(), 16384);
        check("clamp_hat",  longint'(at_target), 1);
        $display("[TB] decim ramp holds at %0d", sdata());

        // Ramp down to idle
        enable = 1'b0; step = 32'h4_0000;
        run_until("down_zero", 0, 5000, e);
        check("down_edges", e, 4098);
        cycle(2);
        check("down_at",   longint'(at_target), 0);
        check("down_ramp", longint'(ramping), 0);
        $display("[TB] ramp down reached 0 in %0d cycles", e);

        // Asynchronous reset mid ramp-down
        enable = 1'b1; target = 16'd16384; step = 0;
        cycle(4);
        enable = 1'b0; step = 32'h4_0000;
        cycle(500);
        check("pre_rst_ramp", longint'(ramping), 1);
        #2 a_resetn = 1'b0;
        #1;
        check("arst_tdata",  sdata(), 0);
        check("arst_tvalid", longint'(SV_AXIS_tvalid), 0);
        check("arst_ramp",   longint'(ramping), 0);
        model_on = 1'b0;
        cycle(2);
        enable = 1'b0; target = 0; step = 0;
        a_resetn = 1'b1;
        cycle(1);
        model_on = 1'b1;
        check("rel_tvalid", longint'(SV_AXIS_tvalid), 1);
        $display("[TB] async reset mid-ramp cleared tdata=%0d", sdata());

        // Randomized segments against the model
        for (int s = 0; s < 60; s++) begin
            int len;
            enable = ($urandom_range(0, 9) < 8);
            target = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       step = 0;
                1:       step = $urandom_range(1, 32'h1_0000);
                2:       step = $urandom_range(32'h1_0000, 32'h40_0000);
                default: step = $urandom;
            endcase
            decim = 16'($urandom_range(0, 3));
            len = $urandom_range(1, 120);
            cycle(len);
            $display("[TB] rand seg %0d en=%0b tgt=%0d step=%0d decim=%0d len=%0d tdata=%0d",
                     s, enable, $signed(target), step, decim, len, sdata());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
